// File: rtl/opfetch_stage.sv
// Operand-fetch stage and ID/EX pipeline register: RAW hazard resolution by bypass or stall.
// Optional feature macro: OPFETCH_FWD_EN (EX/MEM bypass; otherwise stall until writeback).
module opfetch_stage #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 5,
  parameter int CTRL_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  // decoder side
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_pc,
  input  logic [DATA_W-1:0] in_imm,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [ADDR_W-1:0] in_rs1,
  input  logic [ADDR_W-1:0] in_rs2,
  input  logic              in_use_rs1,
  input  logic              in_use_rs2,
  input  logic [ADDR_W-1:0] in_rd,
  input  logic              in_wen,
  input  logic              in_load,
  // register file side
  output logic [ADDR_W-1:0] rf_ra,
  output logic [ADDR_W-1:0] rf_rb,
  input  logic [DATA_W-1:0] rf_busa,
  input  logic [DATA_W-1:0] rf_busb,
  // EX result of the instruction held in the output register
  input  logic [DATA_W-1:0] ex_result,
  // MEM stage
  input  logic              mem_valid,
  input  logic              mem_wen,
  input  logic [ADDR_W-1:0] mem_rd,
  input  logic [DATA_W-1:0] mem_result,
  // redirect
  input  logic              flush,
  // EX side
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_pc,
  output logic [DATA_W-1:0] out_imm,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_rs1_val,
  output logic [DATA_W-1:0] out_rs2_val,
  output logic [ADDR_W-1:0] out_rd,
  output logic              out_wen,
  output logic              out_load
);

  // Handshake: a transfer happens on a posedge where valid && ready are both 1.
  // in_ready never depends on in_valid; out_valid only drops by bubble, flush or reset.

  logic              ex_m1, ex_m2, mem_m1, mem_m2;
  logic              hazard;
  logic              accept;
  logic [DATA_W-1:0] op1, op2;

  assign rf_ra = in_rs1;
  assign rf_rb = in_rs2;

  always_comb begin
    ex_m1  = out_valid && out_wen && (out_rd == in_rs1) && (in_rs1 != '0) && in_use_rs1;
    ex_m2  = out_valid && out_wen && (out_rd == in_rs2) && (in_rs2 != '0) && in_use_rs2;
    mem_m1 = mem_valid && mem_wen && (mem_rd == in_rs1) && (in_rs1 != '0) && in_use_rs1;
    mem_m2 = mem_valid && mem_wen && (mem_rd == in_rs2) && (in_rs2 != '0) && in_use_rs2;
  end

`ifdef OPFETCH_FWD_EN
  // Only a load still in EX cannot supply its value yet.
  always_comb begin
    hazard = out_load && (ex_m1 || ex_m2);

    op1 = rf_busa;
    if (in_rs1 == '0)  op1 = '0;
    else if (ex_m1)    op1 = ex_result;
    else if (mem_m1)   op1 = mem_result;

    op2 = rf_busb;
    if (in_rs2 == '0)  op2 = '0;
    else if (ex_m2)    op2 = ex_result;
    else if (mem_m2)   op2 = mem_result;
  end
`else
  // Without bypass, any in-flight producer of a source blocks until it reaches writeback.
  logic unused_results;
  assign unused_results = ^{ex_result, mem_result};

  always_comb begin
    hazard = ex_m1 || ex_m2 || mem_m1 || mem_m2;
    op1    = (in_rs1 == '0) ? '0 : rf_busa;
    op2    = (in_rs2 == '0) ? '0 : rf_busb;
  end
`endif

  assign in_ready = (!out_valid || out_ready) && !hazard && !flush;
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid   <= 1'b0;
      out_pc      <= '0;
      out_imm     <= '0;
      out_ctrl    <= '0;
      out_rs1_val <= '0;
      out_rs2_val <= '0;
      out_rd      <= '0;
      out_wen     <= 1'b0;
      out_load    <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (accept) begin
      out_valid   <= 1'b1;
      out_pc      <= in_pc;
      out_imm     <= in_imm;
      out_ctrl    <= in_ctrl;
      out_rs1_val <= op1;
      out_rs2_val <= op2;
      out_rd      <= in_rd;
      out_wen     <= in_wen;
      out_load    <= in_load;
    end else if (out_ready) begin
      // EX took the held instruction and nothing replaced it: emit a bubble.
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_opfetch_stage.sv
// Self-checking bench for opfetch_stage: directed hazard scenarios plus randomized traffic
// checked every cycle against a behavioural model of the stage.
module tb_opfetch_stage;

  localparam int DATA_W = 64;
  localparam int ADDR_W = 5;
  localparam int CTRL_W = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid, in_ready;
  logic [DATA_W-1:0] in_pc, in_imm;
  logic [CTRL_W-1:0] in_ctrl;
  logic [ADDR_W-1:0] in_rs1, in_rs2, in_rd;
  logic              in_use_rs1, in_use_rs2, in_wen, in_load;
  logic [ADDR_W-1:0] rf_ra, rf_rb;
  logic [DATA_W-1:0] rf_busa, rf_busb;
  logic [DATA_W-1:0] ex_result;
  logic              mem_valid, mem_wen;
  logic [ADDR_W-1:0] mem_rd;
  logic [DATA_W-1:0] mem_result;
  logic              flush;
  logic              out_valid, out_ready;
  logic [DATA_W-1:0] out_pc, out_imm, out_rs1_val, out_rs2_val;
  logic [CTRL_W-1:0] out_ctrl;
  logic [ADDR_W-1:0] out_rd;
  logic              out_wen, out_load;

  logic [DATA_W-1:0] regfile [32];
  assign rf_busa = regfile[rf_ra];
  assign rf_busb = regfile[rf_rb];

  opfetch_stage #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .CTRL_W(CTRL_W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_imm(in_imm),
    .in_ctrl(in_ctrl), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_use_rs1(in_use_rs1),
    .in_use_rs2(in_use_rs2), .in_rd(in_rd), .in_wen(in_wen), .in_load(in_load),
    .rf_ra(rf_ra), .rf_rb(rf_rb), .rf_busa(rf_busa), .rf_busb(rf_busb),
    .ex_result(ex_result),
    .mem_valid(mem_valid), .mem_wen(mem_wen), .mem_rd(mem_rd), .mem_result(mem_result),
    .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_imm(out_imm),
    .out_ctrl(out_ctrl), .out_rs1_val(out_rs1_val), .out_rs2_val(out_rs2_val),
    .out_rd(out_rd), .out_wen(out_wen), .out_load(out_load)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic              m_live = 1'b0;
  logic              m_valid = 1'b0;
  logic              m_known = 1'b0;
  logic              m_acc = 1'b0;
  logic [DATA_W-1:0] m_pc, m_imm, m_v1, m_v2;
  logic [CTRL_W-1:0] m_ctrl;
  logic [ADDR_W-1:0] m_rd;
  logic              m_wen, m_load;
  logic [63:0]       exp_q[$];

  // {stall, value} for one source: the producer in EX is the model's own held
  // instruction, the producer in MEM is whatever the MEM inputs describe.
  function automatic logic [DATA_W:0] operand(input logic [ADDR_W-1:0] rs, input logic use_it,
                                               input logic [DATA_W-1:0] rf);
    logic in_ex, in_mem, stall;
    logic [DATA_W-1:0] v;
    in_ex  = m_valid && m_wen && m_rd == rs && rs != 0 && use_it;
    in_mem = mem_valid && mem_wen && mem_rd == rs && rs != 0 && use_it;
`ifdef OPFETCH_FWD_EN
    stall = in_ex && m_load;
    v = (rs == 0) ? '0 : in_ex ? ex_result : in_mem ? mem_result : rf;
`else
    stall = in_ex || in_mem;
    v = (rs == 0) ? '0 : rf;
`endif
    return {stall, v};
  endfunction

  function automatic logic model_ready();
    logic [DATA_W:0] a, b;
    a = operand(in_rs1, in_use_rs1, regfile[in_rs1]);
    b = operand(in_rs2, in_use_rs2, regfile[in_rs2]);
    return (!m_valid || out_ready) && !a[DATA_W] && !b[DATA_W] && !flush;
  endfunction

  always @(posedge clk) begin
    logic [DATA_W:0] a, b;
    logic rdy;
    a = operand(in_rs1, in_use_rs1, regfile[in_rs1]);
    b = operand(in_rs2, in_use_rs2, regfile[in_rs2]);
    rdy = model_ready();
    m_acc = 1'b0;
    if (rst) begin
      m_live = 1'b1; m_valid = 1'b0; m_known = 1'b1;
      m_pc = '0; m_imm = '0; m_ctrl = '0; m_v1 = '0; m_v2 = '0;
      m_rd = '0; m_wen = 1'b0; m_load = 1'b0;
      exp_q.delete();
    end else if (m_live) begin
      if (m_valid && (flush || out_ready) && exp_q.size() != 0) void'(exp_q.pop_front());
      if (flush) begin
        m_valid = 1'b0; m_known = 1'b0;
      end else if (in_valid && rdy) begin
        m_valid = 1'b1; m_known = 1'b1; m_acc = 1'b1;
        m_pc = in_pc; m_imm = in_imm; m_ctrl = in_ctrl;
        m_v1 = a[DATA_W-1:0]; m_v2 = b[DATA_W-1:0];
        m_rd = in_rd; m_wen = in_wen; m_load = in_load;
        exp_q.push_back(in_pc);
      end else if (out_ready) begin
        m_valid = 1'b0;
      end
    end
  end

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    if (m_live) begin
      chk("in_ready", in_ready, model_ready());
      chk("rf_ra", rf_ra, in_rs1);
      chk("rf_rb", rf_rb, in_rs2);
      chk("out_valid", out_valid, m_valid);
      if (m_known) begin
        chk("out_pc", out_pc, m_pc);
        chk("out_imm", out_imm, m_imm);
        chk("out_ctrl", out_ctrl, m_ctrl);
        chk("out_rs1_val", out_rs1_val, m_v1);
        chk("out_rs2_val", out_rs2_val, m_v2);
        chk("out_rd", out_rd, m_rd);
        chk("out_wen", out_wen, m_wen);
        chk("out_load", out_load, m_load);
      end
      if (m_valid && out_ready && !flush && !rst && exp_q.size() != 0)
        chk("sb_consumed_pc", out_pc, exp_q[0]);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic at_neg();
    @(negedge clk);
  endtask

  task automatic present(input logic [63:0] pc, input logic [4:0] rs1, input logic u1,
                         input logic [4:0] rs2, input logic u2, input logic [4:0] rd,
                         input logic wen, input logic load);
    in_valid = 1'b1; in_pc = pc; in_imm = pc + 64'h100; in_ctrl = pc[15:0] ^ 16'hA5A5;
    in_rs1 = rs1; in_use_rs1 = u1; in_rs2 = rs2; in_use_rs2 = u2;
    in_rd = rd; in_wen = wen; in_load = load;
  endtask

  task automatic randomize_env();
    out_ready  = $urandom_range(0, 3) != 0;
    flush      = $urandom_range(0, 15) == 0;
    mem_valid  = $urandom_range(0, 1) == 1;
    mem_wen    = $urandom_range(0, 3) != 0;
    mem_rd     = 5'($urandom_range(0, 7));
    mem_result = {$urandom, $urandom};
    ex_result  = {$urandom, $urandom};
    if ($urandom_range(0, 3) == 0) regfile[$urandom_range(0, 7)] = {$urandom, $urandom};
  endtask

  // ---------------- stimulus ----------------
  initial begin
    for (int i = 0; i < 32; i++) regfile[i] = {$urandom, $urandom};
    regfile[0] = 64'hFF;
    rst = 1'b1; flush = 1'b0; out_ready = 1'b1;
    mem_valid = 1'b0; mem_wen = 1'b0; mem_rd = '0; mem_result = '0; ex_result = '0;
    present(64'h0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    in_valid = 1'b0;
    step(); step();
    rst = 1'b0;

    // reset state
    at_neg();
    chk("reset_out_valid", out_valid, 1'b0);
    chk("reset_rs1_val", out_rs1_val, 64'h0);
    chk("reset_in_ready", in_ready, 1'b1);

    // x0 reads are never bypassed or stalled
    present(64'h1000, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0);
    step();
    present(64'h1004, 5'd0, 1'b1, 5'd0, 1'b0, 5'd1, 1'b1, 1'b0);
    ex_result = 64'hFF; mem_result = 64'hFF;
    mem_valid = 1'b1; mem_wen = 1'b1; mem_rd = 5'd0;
    at_neg();
    chk("x0_in_ready", in_ready, 1'b1);
    step();
    chk("x0_out_valid", out_valid, 1'b1);
    chk("x0_rs1_val", out_rs1_val, 64'h0);
    mem_valid = 1'b0;

`ifdef OPFETCH_FWD_EN
    // EX bypass
    present(64'h2000, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0);
    step();
    present(64'h2004, 5'd5, 1'b1, 5'd0, 1'b0, 5'd6, 1'b1, 1'b0);
    ex_result = 64'h1234;
    at_neg();
    chk("exbyp_in_ready", in_ready, 1'b1);
    step();
    chk("exbyp_rs1_val", out_rs1_val, 64'h1234);

    // load-use: one bubble, then MEM bypass
    present(64'h3000, 5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1, 1'b1);
    step();
    present(64'h3004, 5'd0, 1'b0, 5'd7, 1'b1, 5'd8, 1'b1, 1'b0);
    at_neg();
    chk("ldu_in_ready_stall", in_ready, 1'b0);
    step();
    chk("ldu_bubble", out_valid, 1'b0);
    mem_valid = 1'b1; mem_wen = 1'b1; mem_rd = 5'd7; mem_result = 64'hDEAD_BEEF;
    at_neg();
    chk("ldu_in_ready_go", in_ready, 1'b1);
    step();
    chk("ldu_out_valid", out_valid, 1'b1);
    chk("ldu_rs2_val", out_rs2_val, 64'hDEAD_BEEF);
    mem_valid = 1'b0;
`else
    // no bypass: ALU producer of x3 then consumer stalls 2 cycles
    present(64'h2000, 5'd0, 1'b0, 5'd0, 1'b0, 5'd3, 1'b1, 1'b0);
    step();
    regfile[3] = 64'h3333_0000_0000_0003;
    present(64'h2004, 5'd3, 1'b1, 5'd0, 1'b0, 5'd4, 1'b1, 1'b0);
    at_neg();
    chk("nofwd_stall1", in_ready, 1'b0);
    step();
    chk("nofwd_bubble1", out_valid, 1'b0);
    mem_valid = 1'b1; mem_wen = 1'b1; mem_rd = 5'd3;
    at_neg();
    chk("nofwd_stall2", in_ready, 1'b0);
    step();
    chk("nofwd_bubble2", out_valid, 1'b0);
    mem_valid = 1'b0;
    at_neg();
    chk("nofwd_go", in_ready, 1'b1);
    step();
    chk("nofwd_out_valid", out_valid, 1'b1);
    chk("nofwd_rs1_val", out_rs1_val, 64'h3333_0000_0000_0003);
`endif

    // backpressure then flush
    present(64'h4000, 5'd0, 1'b0, 5'd0, 1'b0, 5'd2, 1'b0, 1'b0);
    step();
    out_ready = 1'b0;
    present(64'h4004, 5'd0, 1'b0, 5'd0, 1'b0, 5'd2, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      at_neg();
      chk("bp_in_ready", in_ready, 1'b0);
      step();
      chk("bp_out_valid", out_valid, 1'b1);
      chk("bp_out_pc", out_pc, 64'h4000);
      chk("bp_out_imm", out_imm, 64'h4100);
    end
    flush = 1'b1;
    at_neg();
    chk("flush_in_ready", in_ready, 1'b0);
    step();
    chk("flush_out_valid", out_valid, 1'b0);
    flush = 1'b0;

    // reset in the middle of a stall
    step();
    chk("mid_accept_pc", out_pc, 64'h4004);
    present(64'h5000, 5'd0, 1'b0, 5'd0, 1'b0, 5'd2, 1'b0, 1'b0);
    at_neg();
    chk("mid_stall_in_ready", in_ready, 1'b0);
    rst = 1'b1;
    step();
    chk("midrst_out_valid", out_valid, 1'b0);
    chk("midrst_out_pc", out_pc, 64'h0);
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    step();

    // randomized traffic; an unaccepted instruction is held stable
    repeat (3000) begin
      rst = ($urandom_range(0, 199) == 0);
      if (!(in_valid && !m_acc)) begin
        present({$urandom, $urandom}, 5'($urandom_range(0, 7)), $urandom_range(0, 3) != 0,
                5'($urandom_range(0, 7)), $urandom_range(0, 3) != 0,
                5'($urandom_range(0, 7)), $urandom_range(0, 3) != 0,
                $urandom_range(0, 2) == 0);
        in_imm   = {$urandom, $urandom};
        in_ctrl  = 16'($urandom);
        in_valid = $urandom_range(0, 3) != 0;
      end
      randomize_env();
      step();
    end

    rst = 1'b0; flush = 1'b0;
    step(); step();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
